// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity-mode codes and a small helper to decode whether a parity bit is sent.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Mode 3 is reserved and behaves like PAR_NONE.
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles while enabled and pulses bit_done on the
// last cycle of each serial bit, wrapping to zero at every bit boundary.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = enable && (cnt_q == LAST);

    // Next count: hold when idle, wrap on the final cycle of a bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (bit_done) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts one word per handshake and serialises it as
// start bit, LSB-first data, optional parity and one or two stop bits.
// tx and busy come straight from flops so the line never glitches.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 parity_q, parity_d;
    logic [1:0]           mode_q, mode_d;
    logic                 two_stop_q, two_stop_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 bit_done;

    assign s_ready     = (state_q == IDLE);
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign timer_clear = (state_q == IDLE);
    assign timer_en    = (state_q != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .bit_done(bit_done)
    );

    // Next-state logic; tx_d is the level of the bit being entered, so the
    // registered tx lines up with the state from its first cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        parity_d   = parity_q;
        mode_d     = mode_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d    = START;
                    shift_d    = s_data;
                    mode_d     = parity_mode;
                    two_stop_d = two_stop;
                    idx_d      = '0;
                    parity_d   = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    parity_d = parity_q ^ shift_q[0];
                    shift_d  = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (has_parity(mode_q)) begin
                            state_d = PARITY;
                            tx_d    = parity_q ^ shift_q[0] ^ (mode_q == PAR_ODD);
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                // idx_q doubles as the stop-bit counter once data is done.
                if (bit_done) begin
                    if (two_stop_q && (idx_q == '0)) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame registers; reset abandons any frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            parity_q   <= 1'b0;
            mode_q     <= PAR_NONE;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            parity_q   <= parity_d;
            mode_q     <= mode_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: a frame-level model predicts
// tx/busy/s_ready every cycle, a sampling receiver decodes the line, and
// directed cases pin frame lengths and bit patterns with literal values.
module tb_uart_tx_framer;

    localparam int D = 8;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [D-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [1:0]   parity_mode;
    logic         two_stop;
    logic         tx;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_framer #(
        .DATA_BITS   (D),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: list of line levels for the accepted frame.
    bit           m_active = 1'b0;
    int           m_cyc    = 0;
    int           m_len    = 0;
    int           m_nb     = 0;
    logic         m_bits[16];
    logic [D-1:0] m_data;

    // Line receiver working from the DUT's tx.
    int           rx_state = 0;
    int           rx_cnt   = 0;
    int           rx_nb    = 0;
    logic [D-1:0] rx_val;
    logic [D-1:0] rx_q[$];

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 'x;
    endfunction

    // Model update on the active edge, comparison and receiver on the falling edge.
    initial begin
        logic exp_tx;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_cyc++;
                if (m_cyc == m_len) m_active = 1'b0;
            end else if (s_valid === 1'b1) begin
                m_data = s_data;
                m_nb = 0;
                m_bits[m_nb] = 1'b0; m_nb++;
                for (int i = 0; i < D; i++) begin
                    m_bits[m_nb] = s_data[i]; m_nb++;
                end
                if (parity_mode == 2'd1 || parity_mode == 2'd2) begin
                    m_bits[m_nb] = (^s_data) ^ (parity_mode == 2'd2); m_nb++;
                end
                m_bits[m_nb] = 1'b1; m_nb++;
                if (two_stop) begin
                    m_bits[m_nb] = 1'b1; m_nb++;
                end
                m_len    = m_nb * C;
                m_cyc    = 0;
                m_active = 1'b1;
            end

            @(negedge clk);
            if (!rst_n) m_active = 1'b0;
            exp_tx = m_active ? m_bits[m_cyc / C] : 1'b1;
            check("tx", 32'(tx), 32'(exp_tx));
            check("busy", 32'(busy), 32'(m_active));
            check("s_ready", 32'(s_ready), 32'(!m_active));

            case (rx_state)
                0: begin
                    if (busy === 1'b1 && tx === 1'b0) begin
                        rx_state = 1; rx_cnt = 0; rx_nb = 0; rx_val = '0;
                    end
                end
                1: begin
                    if (busy !== 1'b1) begin
                        rx_state = 0;
                    end else begin
                        rx_cnt++;
                        if (rx_cnt == C / 2 + C * (rx_nb + 1)) begin
                            rx_val[rx_nb] = tx;
                            rx_nb++;
                            if (rx_nb == D) begin
                                rx_q.push_back(rx_val);
                                check("rx_data", 32'(rx_val), 32'(m_data));
                                rx_state = 2;
                            end
                        end
                    end
                end
                default: begin
                    if (busy !== 1'b1) rx_state = 0;
                end
            endcase
        end
    end

    task automatic wait_ready();
        bit got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1 && busy === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_timeout", 32'(s_ready), 32'd1);
    endtask

    task automatic send(input logic [D-1:0] d, input logic [1:0] m, input logic ts, input bit hold);
        wait_ready();
        #1;
        s_data      = d;
        parity_mode = m;
        two_stop    = ts;
        s_valid     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
    endtask

    // Counts busy cycles of the frame just accepted and samples each bit mid-way.
    task automatic measure(output int len, output logic [15:0] bits, output int nb);
        bit done = 1'b0;
        len  = 0;
        nb   = 0;
        bits = '0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (len % C == C / 2 && nb < 16) begin
                bits[nb] = tx;
                nb++;
            end
            len++;
        end
        if (!done) check("frame_end_timeout", 32'(busy), 32'd0);
    endtask

    // Waits for the current frame to end, then counts idle cycles before the next.
    task automatic idle_gap(output int gap);
        bit fell = 1'b0;
        gap = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                fell = 1'b1;
                break;
            end
        end
        if (!fell) check("busy_fall_timeout", 32'(busy), 32'd0);
        gap = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
            gap++;
        end
    endtask

    initial begin
        int          len;
        int          nb;
        int          gap;
        logic [15:0] bits;

        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        parity_mode = 2'd0;
        two_stop    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(s_ready), 32'd1);

        // 0x55, no parity, one stop.
        send(8'h55, 2'd0, 1'b0, 1'b0);
        check("model_len_55", 32'(m_len), 32'd160);
        measure(len, bits, nb);
        check("len_55", 32'(len), 32'd160);
        check("nbits_55", 32'(nb), 32'd10);
        check("pattern_55", 32'(bits[9:0]), 32'h2AA);

        // 0xA5 even then odd parity.
        send(8'hA5, 2'd1, 1'b0, 1'b0);
        measure(len, bits, nb);
        check("len_a5_even", 32'(len), 32'd176);
        check("par_a5_even", 32'(bits[9]), 32'd0);
        send(8'hA5, 2'd2, 1'b0, 1'b0);
        measure(len, bits, nb);
        check("len_a5_odd", 32'(len), 32'd176);
        check("par_a5_odd", 32'(bits[9]), 32'd1);

        // 0xFF odd parity, two stop bits.
        send(8'hFF, 2'd2, 1'b1, 1'b0);
        check("model_len_ff", 32'(m_len), 32'd192);
        measure(len, bits, nb);
        check("len_ff", 32'(len), 32'd192);
        check("nbits_ff", 32'(nb), 32'd12);
        check("tail_ff", 32'(bits[11:9]), 32'h7);

        // Back-to-back with s_valid held.
        rx_q.delete();
        send(8'h12, 2'd0, 1'b0, 1'b1);
        s_data = 8'h34;
        idle_gap(gap);
        #1 s_valid = 1'b0;
        check("b2b_gap", 32'(gap), 32'd1);
        wait_ready();
        check("b2b_count", 32'(rx_q.size()), 32'd2);
        check("b2b_first", rx_at(0), 32'h12);
        check("b2b_second", rx_at(1), 32'h34);

        // Inputs changed mid-frame while s_valid stays high.
        rx_q.delete();
        send(8'h3C, 2'd1, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        #1;
        s_data      = 8'hC3;
        parity_mode = 2'd2;
        two_stop    = 1'b1;
        idle_gap(gap);
        #1 s_valid = 1'b0;
        wait_ready();
        check("chg_count", 32'(rx_q.size()), 32'd2);
        check("chg_first", rx_at(0), 32'h3C);
        check("chg_second", rx_at(1), 32'hC3);

        // Reset pulse during data bit 3, then a clean frame.
        rx_q.delete();
        send(8'h5A, 2'd0, 1'b0, 1'b0);
        repeat (C * 4 + 6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(s_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        send(8'h81, 2'd2, 1'b1, 1'b0);
        measure(len, bits, nb);
        check("len_81", 32'(len), 32'd192);
        check("pattern_81", 32'(bits[11:0]), 32'hF02);
        check("rst_rx_count", 32'(rx_q.size()), 32'd1);
        check("rst_rx_data", rx_at(0), 32'h81);

        // Randomised traffic; the per-cycle model does the checking.
        repeat (6000) begin
            @(negedge clk);
            #1;
            s_valid     = ($urandom_range(0, 3) == 0);
            s_data      = D'($urandom);
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
        end
        s_valid = 1'b0;
        wait_ready();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
